// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared image geometry defaults and column packing helper
package conv_pkg;

  localparam int DEF_IMG_HEIGHT  = 480;
  localparam int DEF_IMG_WIDTH   = 640;
  localparam int DEF_IMG_NB      = 7;
  localparam int DEF_KERNEL_SIZE = 3;
  localparam int DEF_KERNEL_NB   = 8;

  // MSB of row r inside a packed column; row 0 sits in the top bits.
  function automatic int row_msb(input int height, input int nb, input int r);
    return height * nb - 1 - nb * r;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - modulo-(MAX+1) counter with load-zero that can combine with a same-cycle step
module wrap_counter #(
  parameter int MAX = 1,
  parameter int W   = (MAX > 0) ? $clog2(MAX + 1) : 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         at_max_o
);

  logic [W-1:0] cnt_q, cnt_d, base;

  // clr and en together give "zero, then step", i.e. the value 1.
  always_comb begin
    base  = clr_i ? '0 : cnt_q;
    cnt_d = base;
    if (en_i) cnt_d = (base == W'(MAX)) ? '0 : base + W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o    = cnt_q;
  assign at_max_o = (cnt_q == W'(MAX));

endmodule

// File: rtl/column_loader.sv
// rtl/column_loader.sv - assembles a column-major pixel stream into double-buffered packed columns
module column_loader
  import conv_pkg::*;
#(
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_NB     = DEF_IMG_NB,
  parameter int IDX_W      = $clog2(IMG_WIDTH)
) (
  input  logic                         clk100,
  input  logic                         in_reset,
  input  logic [IMG_NB-1:0]            i_pix,
  input  logic                         i_pix_valid,
  input  logic                         i_sof,
  output logic                         o_pix_ready,
  output logic [IMG_HEIGHT*IMG_NB-1:0] o_col,
  output logic                         o_col_valid,
  input  logic                         i_col_ready,
  output logic [IDX_W-1:0]             o_col_idx,
  output logic                         o_last_col,
  output logic                         o_sync_err
);

  localparam int COL_W = IMG_HEIGHT * IMG_NB;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic [COL_W-1:0] fill_q, fill_d, col_q, col_d;
  logic             fill_full_q, fill_full_d;
  logic             col_valid_q, col_valid_d;
  logic             last_col_q, last_col_d;
  logic             sync_err_q, sync_err_d;
  logic [IDX_W-1:0] col_idx_q, col_idx_d;

  logic [ROW_W-1:0] row_ptr, wr_row;
  logic [IDX_W-1:0] col_cnt;
  logic             row_at_max, col_at_max;
  logic             accept, sof_acc, out_free, xfer, last_row_acc;

  assign out_free     = !col_valid_q || i_col_ready;
  assign o_pix_ready  = !fill_full_q || out_free;
  assign accept       = i_pix_valid && o_pix_ready;
  assign sof_acc      = accept && i_sof;
  assign xfer         = fill_full_q && out_free;
  assign wr_row       = i_sof ? '0 : row_ptr;
  assign last_row_acc = accept && (i_sof ? (IMG_HEIGHT == 1) : row_at_max);

  wrap_counter #(.MAX(IMG_HEIGHT - 1), .W(ROW_W)) u_row_ptr (
    .clk_i    (clk100),
    .rst_ni   (in_reset),
    .en_i     (accept),
    .clr_i    (sof_acc),
    .cnt_o    (row_ptr),
    .at_max_o (row_at_max)
  );

  // A start-of-frame pins the filling column to index 0, overriding the transfer step.
  wrap_counter #(.MAX(IMG_WIDTH - 1), .W(IDX_W)) u_col_cnt (
    .clk_i    (clk100),
    .rst_ni   (in_reset),
    .en_i     (xfer && !sof_acc),
    .clr_i    (sof_acc),
    .cnt_o    (col_cnt),
    .at_max_o (col_at_max)
  );

  always_comb begin
    fill_d = fill_q;
    for (int r = 0; r < IMG_HEIGHT; r++) begin
      if (accept && wr_row == ROW_W'(r)) fill_d[row_msb(IMG_HEIGHT, IMG_NB, r) -: IMG_NB] = i_pix;
    end
    fill_full_d = (fill_full_q && !xfer) || last_row_acc;
    col_d       = xfer ? fill_q : col_q;
    col_idx_d   = xfer ? col_cnt : col_idx_q;
    last_col_d  = xfer ? col_at_max : last_col_q;
    col_valid_d = xfer || (col_valid_q && !i_col_ready);
    sync_err_d  = sync_err_q || (sof_acc && row_ptr != '0);
  end

  always_ff @(posedge clk100 or negedge in_reset) begin
    if (!in_reset) begin
      fill_q      <= '0;
      fill_full_q <= 1'b0;
      col_q       <= '0;
      col_valid_q <= 1'b0;
      col_idx_q   <= '0;
      last_col_q  <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      fill_q      <= fill_d;
      fill_full_q <= fill_full_d;
      col_q       <= col_d;
      col_valid_q <= col_valid_d;
      col_idx_q   <= col_idx_d;
      last_col_q  <= last_col_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign o_col       = col_q;
  assign o_col_valid = col_valid_q;
  assign o_col_idx   = col_idx_q;
  assign o_last_col  = last_col_q;
  assign o_sync_err  = sync_err_q;

endmodule

// File: tb/tb_column_loader.sv
// tb/tb_column_loader.sv - self-checking bench for column_loader with a queue-based column model
module tb_column_loader;

  localparam int H  = 16;
  localparam int W  = 10;
  localparam int NB = 7;
  localparam int IW = $clog2(W);
  localparam int CW = H * NB;

  logic          clk100 = 1'b0;
  logic          in_reset = 1'b0;
  logic [NB-1:0] i_pix = '0;
  logic          i_pix_valid = 1'b0;
  logic          i_sof = 1'b0;
  logic          o_pix_ready;
  logic [CW-1:0] o_col;
  logic          o_col_valid;
  logic          i_col_ready = 1'b0;
  logic [IW-1:0] o_col_idx;
  logic          o_last_col;
  logic          o_sync_err;

  always #5 clk100 = ~clk100;

  column_loader #(.IMG_HEIGHT(H), .IMG_WIDTH(W), .IMG_NB(NB), .IDX_W(IW)) dut (
    .clk100      (clk100),
    .in_reset    (in_reset),
    .i_pix       (i_pix),
    .i_pix_valid (i_pix_valid),
    .i_sof       (i_sof),
    .o_pix_ready (o_pix_ready),
    .o_col       (o_col),
    .o_col_valid (o_col_valid),
    .i_col_ready (i_col_ready),
    .o_col_idx   (o_col_idx),
    .o_last_col  (o_last_col),
    .o_sync_err  (o_sync_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: pixels of the column being gathered, one completed column
  // waiting for the output slot, and the column currently offered downstream.
  logic [NB-1:0] part[$];
  bit            pend_v, out_v, m_err;
  int            pend_idx, out_idx, next_idx;
  logic [CW-1:0] pend_bus, out_bus;

  function automatic logic [CW-1:0] pack_part();
    logic [CW-1:0] v = '0;
    for (int r = 0; r < H; r++) v[CW-1-NB*r -: NB] = part[r];
    return v;
  endfunction

  task automatic model_reset();
    part.delete();
    pend_v = 0; out_v = 0; m_err = 0;
    pend_idx = 0; out_idx = 0; next_idx = 0;
    pend_bus = '0; out_bus = '0;
  endtask

  task automatic cycle(input bit v, input bit s, input logic [NB-1:0] p, input bit cr, output bit acc);
    bit ofree, rdy, xf;
    i_pix_valid = v; i_sof = s; i_pix = p; i_col_ready = cr;
    ofree = !out_v || cr;
    rdy   = !pend_v || ofree;
    xf    = pend_v && ofree;
    acc   = v && rdy;
    @(negedge clk100);
    chk("pix_ready", CW'(o_pix_ready), CW'(rdy));
    chk("col_valid", CW'(o_col_valid), CW'(out_v));
    if (out_v) begin
      chk("col_data", o_col, out_bus);
      chk("col_idx", CW'(o_col_idx), CW'(out_idx));
      chk("last_col", CW'(o_last_col), CW'(out_idx == W - 1));
    end
    chk("sync_err", CW'(o_sync_err), CW'(m_err));
    @(posedge clk100);
    if (xf) begin
      out_bus = pend_bus; out_idx = pend_idx; out_v = 1; pend_v = 0;
    end else if (out_v && cr) begin
      out_v = 0;
    end
    if (acc) begin
      if (s) begin
        if (part.size() != 0) m_err = 1;
        part.delete();
        next_idx = 0;
      end
      part.push_back(p);
      if (part.size() == H) begin
        pend_bus = pack_part(); pend_idx = next_idx; pend_v = 1;
        next_idx = (next_idx + 1) % W;
        part.delete();
      end
    end
    #1;
  endtask

  typedef struct {
    int n; bit pix; bit sof; int val; bit ramp; bit cr;
    bit e_rdy; bit e_val; int e_idx; bit e_err;
  } phase_t;

  phase_t ph[12];

  initial begin
    bit acc;
    int got, cyc, stalls, emitted, lasts;
    logic [NB-1:0] pv;

    ph[0]  = '{16, 1, 1,  0, 1, 1, 1, 0, 0, 0};
    ph[1]  = '{ 1, 0, 0,  0, 0, 0, 1, 1, 0, 0};
    ph[2]  = '{ 1, 0, 0,  0, 0, 1, 1, 0, 0, 0};
    ph[3]  = '{16, 1, 0,  5, 0, 0, 1, 0, 0, 0};
    ph[4]  = '{16, 1, 0,  9, 0, 0, 0, 1, 1, 0};
    ph[5]  = '{ 2, 0, 0,  0, 0, 0, 0, 1, 1, 0};
    ph[6]  = '{ 1, 0, 0,  0, 0, 1, 1, 1, 2, 0};
    ph[7]  = '{ 1, 0, 0,  0, 0, 1, 1, 0, 0, 0};
    ph[8]  = '{ 5, 1, 0, 20, 1, 1, 1, 0, 0, 0};
    ph[9]  = '{16, 1, 1, 40, 1, 1, 1, 0, 0, 1};
    ph[10] = '{ 1, 0, 0,  0, 0, 1, 1, 1, 0, 1};
    ph[11] = '{ 1, 0, 0,  0, 0, 1, 1, 0, 0, 1};

    model_reset();
    repeat (3) @(posedge clk100);
    #1;
    chk("rst_col", o_col, '0);
    chk("rst_valid", CW'(o_col_valid), '0);
    chk("rst_idx", CW'(o_col_idx), '0);
    chk("rst_last", CW'(o_last_col), '0);
    chk("rst_err", CW'(o_sync_err), '0);
    @(negedge clk100);
    in_reset = 1'b1;
    #1;
    chk("rst_ready", CW'(o_pix_ready), CW'(1));
    @(posedge clk100);
    #1;

    for (int p = 0; p < 12; p++) begin
      if (ph[p].pix) begin
        got = 0; cyc = 0;
        while (got < ph[p].n && cyc < 200) begin
          pv = ph[p].ramp ? NB'(ph[p].val + got) : NB'(ph[p].val);
          cycle(1'b1, ph[p].sof && got == 0, pv, ph[p].cr, acc);
          if (acc) got++;
          cyc++;
        end
        chk("phase_timeout", CW'(got), CW'(ph[p].n));
      end else begin
        for (int k = 0; k < ph[p].n; k++) cycle(1'b0, 1'b0, '0, ph[p].cr, acc);
      end
      chk("ph_ready", CW'(o_pix_ready), CW'(ph[p].e_rdy));
      chk("ph_valid", CW'(o_col_valid), CW'(ph[p].e_val));
      chk("ph_err", CW'(o_sync_err), CW'(ph[p].e_err));
      if (ph[p].e_val) chk("ph_idx", CW'(o_col_idx), CW'(ph[p].e_idx));
      if (p == 1) for (int r = 0; r < H; r++) chk("basic_slice", CW'(o_col[CW-1-NB*r -: NB]), CW'(r % 128));
      if (p == 5) chk("bp_slice", CW'(o_col[NB-1:0]), CW'(5));
      if (p == 6) chk("bp_slice", CW'(o_col[CW-1 -: NB]), CW'(9));
      if (p == 10) chk("resync_row0", CW'(o_col[CW-1 -: NB]), CW'(40));
    end

    stalls = 0; emitted = 0; lasts = 0;
    for (int k = 0; k < 12 * H + 3; k++) begin
      cycle(k < 12 * H, 1'b0, NB'($urandom), 1'b1, acc);
      if (k < 12 * H && !acc) stalls++;
      if (o_col_valid) emitted++;
      if (o_col_valid && o_last_col) lasts++;
    end
    chk("wrap_stalls", CW'(stalls), '0);
    chk("wrap_emitted", CW'(emitted), CW'(12));
    chk("wrap_lasts", CW'(lasts), CW'(1));

    cycle(1'b1, 1'b1, 7'd3, 1'b1, acc);
    for (int k = 0; k < H + 7; k++) cycle(1'b1, 1'b0, NB'($urandom), 1'b0, acc);
    chk("pre_rst_valid", CW'(o_col_valid), CW'(1));
    i_pix_valid = 1'b0; i_sof = 1'b0;
    in_reset = 1'b0;
    #1;
    chk("mid_rst_valid", CW'(o_col_valid), '0);
    chk("mid_rst_col", o_col, '0);
    chk("mid_rst_idx", CW'(o_col_idx), '0);
    chk("mid_rst_err", CW'(o_sync_err), '0);
    model_reset();
    @(negedge clk100);
    in_reset = 1'b1;
    @(posedge clk100);
    #1;
    for (int k = 0; k < H; k++) cycle(1'b1, 1'b0, NB'(k + 60), 1'b1, acc);
    cycle(1'b0, 1'b0, '0, 1'b1, acc);
    chk("post_rst_valid", CW'(o_col_valid), CW'(1));
    chk("post_rst_idx", CW'(o_col_idx), '0);

    for (int k = 0; k < 4000; k++) begin
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3, NB'($urandom),
            $urandom_range(0, 9) < 6, acc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/column_loader.md
Name: column_loader

Overview:
- Upstream feeder for the Convolution stage.
- Takes a raster-ordered, column-major pixel stream one pixel per cycle and assembles each image column of IMG_HEIGHT pixels into the packed column bus that Convolution consumes on i_col.
- Double-buffered: one fill register and one output register. The next column fills while the current one is held for downstream.
- Valid/ready handshakes on both sides. Tracks column index and frame boundaries.

Parameters:
IMG_HEIGHT, 480, pixels per column (rows)
IMG_WIDTH, 640, columns per frame
IMG_NB, 7, bits per pixel
IDX_W, $clog2(IMG_WIDTH), width of column index

Ports:
clk100  input  1  system clock, all logic on rising edge
in_reset  input  1  asynchronous active-low reset
i_pix  input  IMG_NB  pixel value
i_pix_valid  input  1  pixel present
i_sof  input  1  qualifies i_pix as row 0 of column 0 of a new frame
o_pix_ready  output  1  loader can accept a pixel this cycle
o_col  output  IMG_HEIGHT*IMG_NB  packed column; row r at [(IMG_HEIGHT*IMG_NB-1)-IMG_NB*r -: IMG_NB]
o_col_valid  output  1  o_col holds a complete column
i_col_ready  input  1  downstream consumes o_col this cycle
o_col_idx  output  IDX_W  column index of o_col within frame
o_last_col  output  1  o_col is column IMG_WIDTH-1
o_sync_err  output  1  sticky: i_sof arrived with a partially filled column

Behaviour:
- Reset (in_reset=0, asynchronous):
  - o_col=0, o_col_valid=0, o_col_idx=0, o_last_col=0, o_sync_err=0.
  - Fill register cleared; row_ptr=0, col_cnt=0, fill_full=0.
  - o_pix_ready=1 once out of reset.
  - Reset mid-column discards the partial column; o_col_valid drops immediately.
- Definitions:
  - accept = i_pix_valid && o_pix_ready.
  - out_free = !o_col_valid || i_col_ready.
  - xfer = fill_full && out_free.
  - o_pix_ready = !fill_full || out_free (combinational path from i_col_ready; this is intentional).
- Fill:
  - On accept, i_pix is written to fill row row_ptr.
  - row_ptr increments and wraps to 0 after IMG_HEIGHT-1.
  - Accepting row IMG_HEIGHT-1 sets fill_full.
- Transfer: on xfer, at the same edge:
  - o_col <= fill.
  - o_col_valid <= 1.
  - o_col_idx <= col_cnt.
  - o_last_col <= (col_cnt == IMG_WIDTH-1).
  - col_cnt increments and wraps after IMG_WIDTH-1.
  - fill_full <= 0 unless this same edge accepts the last row again (only possible when IMG_HEIGHT=1).
  - A pixel accepted on the same edge writes row 0 of the next column. There is no bubble at column boundaries.
- Output handshake:
  - If o_col_valid && i_col_ready && !xfer, o_col_valid <= 0.
  - While o_col_valid && !i_col_ready, o_col, o_col_idx and o_last_col are held stable.
- Latency: last row accepted at edge k -> o_col_valid=1 after edge k+1 if the output slot is free; otherwise after the first edge where i_col_ready=1.
- Throughput:
  - One pixel per cycle sustained when i_col_ready=1.
  - Backpressure: when fill is full and the output is held, o_pix_ready=0.
  - Pixels with i_pix_valid=1 while o_pix_ready=0 are not consumed; the source holds them.
- i_sof (only meaningful on an accepted pixel):
  - The pixel is written as row 0 and row_ptr <= 1.
  - col_cnt is forced so the column being filled gets index 0. This overrides the increment if xfer happens on the same edge; the transferring column keeps its old index.
  - If row_ptr != 0 before that edge, o_sync_err <= 1 and the partial rows are discarded.
  - o_sync_err clears only on reset.
- Arithmetic: counters are unsigned and wrap exactly at their bound; no other arithmetic.

Decomposition:
- Shared package conv_pkg:
  - IMG_HEIGHT, IMG_WIDTH, IMG_NB, KERNEL_SIZE, KERNEL_NB defaults.
  - A row-slice MSB offset function used here and by Convolution, so packing stays identical.
- One sub-module: wrap_counter (parameter MAX; ports enable, load-zero, count, at_max). It is instantiated for row_ptr and for col_cnt.

Test Plan:
- Basic fill:
  - Stimulus: after reset, stream 480 pixels with value r mod 128 (row 0 with i_sof=1), i_col_ready=1.
  - Response: o_col_valid pulses one cycle, 2 edges after the last pixel; slice r == r mod 128; o_col_idx=0; o_last_col=0; o_pix_ready stays 1.
- Backpressure:
  - Stimulus: i_col_ready=0, stream two full columns (values 5 then 9).
  - Response: o_col holds all-5; o_pix_ready drops after the 960th pixel. Raise i_col_ready for one cycle; next o_col is all-9 and o_pix_ready returns to 1 in that cycle.
- Frame wrap:
  - Stimulus: stream 640 columns continuously.
  - Response: o_col_idx counts 0..639; o_last_col=1 only at idx 639; next column has idx 0; no idle cycles in pixel acceptance.
- Resync:
  - Stimulus: 100 pixels, then a pixel with i_sof=1 followed by 479 more.
  - Response: o_sync_err=1 and stays 1; the emitted column starts with the i_sof pixel; o_col_idx=0.
- Reset mid-operation:
  - Stimulus: drop in_reset for 1 cycle while o_col_valid=1 and row_ptr=200.
  - Response: o_col_valid=0 and o_col=0 immediately; next full 480-pixel column emits normally with idx 0.
